// File: rtl/led_pattern_pkg.sv
// Shared mode codes, control FSM encoding and width helper for the LED pattern generator.
// No logic and no flow control of its own.
package led_pattern_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_BLINK   = 2'd1;
  localparam logic [1:0] MODE_PWM     = 2'd2;
  localparam logic [1:0] MODE_STRETCH = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam int LOCK_LOSS_W = 8;

  // Bits needed to hold the value v; never less than one.
  function automatic int bits_for(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: event edge detect, stretch counter, mode mux and output flop.
// LED is registered (1 cycle after cnt/mode/stretch state); no backpressure.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int CNT_W       = 25,
  parameter int PWM_W       = 8,
  parameter int STRETCH_CYC = 2**20,
  parameter int CH_IDX      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic [PWM_W-1:0] duty,
  input  logic             event_in,
  output logic             led
);

  localparam int              ST_W    = bits_for(STRETCH_CYC);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYC);
  localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);

  logic            ev_prev_q, ev_prev_d;
  logic [ST_W-1:0] stretch_q, stretch_d;
  logic            led_q, led_d;
  logic            ev_rise;
  logic            unused_cnt;

  // Each channel only looks at its blink bit and the PWM phase bits.
  assign unused_cnt = ^cnt;

  always_comb begin
    ev_rise   = event_in & ~ev_prev_q;
    // Cleared outside RUN so a level held high across RUN entry still fires once.
    ev_prev_d = run & event_in;

    stretch_d = '0;
    if (run && mode == MODE_STRETCH) begin
      if (ev_rise) begin
        stretch_d = ST_LOAD;
      end else if (stretch_q != '0) begin
        stretch_d = stretch_q - ST_ONE;
      end
    end

    led_d = 1'b0;
    if (run) begin
      case (mode)
        MODE_BLINK:   led_d = cnt[CNT_W-1-CH_IDX];
        MODE_PWM:     led_d = (cnt[PWM_W-1:0] < duty);
        MODE_STRETCH: led_d = (stretch_q != '0);
        default:      led_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_prev_q <= 1'b0;
      stretch_q <= '0;
      led_q     <= 1'b0;
    end else begin
      ev_prev_q <= ev_prev_d;
      stretch_q <= stretch_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator gated on a synchronised MMCM lock plus settle delay.
// RUN starts SETTLE_CYC cycles after SETTLE entry (3 edges after lock rise); LEDs registered; no backpressure.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 25,
  parameter int PWM_W       = 8,
  parameter int SETTLE_CYC  = 1024,
  parameter int STRETCH_CYC = 2**20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    locked,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [PWM_W*NUM_CH-1:0] duty,
  input  logic [NUM_CH-1:0]       event_in,
  output logic [NUM_CH-1:0]       led,
  output logic                    running,
  output logic [LOCK_LOSS_W-1:0]  lock_loss_cnt
);

  localparam int                     SET_W       = bits_for(SETTLE_CYC - 1);
  localparam logic [SET_W-1:0]       SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [SET_W-1:0]       SET_ONE     = SET_W'(1);
  localparam logic [CNT_W-1:0]       CNT_ONE     = CNT_W'(1);
  localparam logic [LOCK_LOSS_W-1:0] LL_ONE      = LOCK_LOSS_W'(1);
  localparam logic [LOCK_LOSS_W-1:0] LL_MAX      = '1;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   lock_s_q, lock_s_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LOCK_LOSS_W-1:0] lock_loss_q, lock_loss_d;
  logic                   running_q, running_d;
  logic                   run;

  assign run = (state_q == ST_RUN);

  always_comb begin
    sync1_d     = locked;
    lock_s_d    = sync1_q;
    state_d     = state_q;
    settle_d    = '0;
    lock_loss_d = lock_loss_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s_q) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q + SET_ONE;
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          if (lock_loss_q != LL_MAX) lock_loss_d = lock_loss_q + LL_ONE;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    // Held at zero on both RUN entry and exit, so it reads 0 in every non-RUN cycle.
    cnt_d     = (run && state_d == ST_RUN) ? cnt_q + CNT_ONE : '0;
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_LOCK;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      settle_q    <= '0;
      cnt_q       <= '0;
      lock_loss_q <= '0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      lock_s_q    <= lock_s_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      lock_loss_q <= lock_loss_d;
      running_q   <= running_d;
    end
  end

  assign running       = running_q;
  assign lock_loss_cnt = lock_loss_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .CNT_W      (CNT_W),
      .PWM_W      (PWM_W),
      .STRETCH_CYC(STRETCH_CYC),
      .CH_IDX     (i)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .cnt      (cnt_q),
      .run      (run),
      .mode     (mode[2*i +: 2]),
      .duty     (duty[PWM_W*i +: PWM_W]),
      .event_in (event_in[i]),
      .led      (led[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised and directed bench for led_pattern_gen against a cycle-level behavioural model.
// Model tracks time-since-RUN and time-since-trigger with plain integers.
module tb_led_pattern_gen;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 6;
  localparam int PWM_W       = 4;
  localparam int SETTLE_CYC  = 8;
  localparam int STRETCH_CYC = 5;
  localparam int PH_WAIT = 0, PH_SETTLE = 1, PH_RUN = 2;
  localparam int NO_TRIG = -1000000;

  logic                    clk;
  logic                    rst_n;
  logic                    locked;
  logic [2*NUM_CH-1:0]     mode;
  logic [PWM_W*NUM_CH-1:0] duty;
  logic [NUM_CH-1:0]       event_in;
  logic [NUM_CH-1:0]       led;
  logic                    running;
  logic [7:0]              lock_loss_cnt;

  led_pattern_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_W(PWM_W),
    .SETTLE_CYC(SETTLE_CYC), .STRETCH_CYC(STRETCH_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .mode(mode), .duty(duty),
    .event_in(event_in), .led(led), .running(running), .lock_loss_cnt(lock_loss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int              m_phase, m_settle, m_run_age, m_llc, m_edge;
  bit              m_sync1, m_lock_s, m_running;
  bit [NUM_CH-1:0] m_prev_ev, m_led;
  int              m_trig [NUM_CH];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_WAIT; m_settle = 0; m_run_age = 0; m_llc = 0; m_edge = 0;
    m_sync1 = 0; m_lock_s = 0; m_running = 0; m_prev_ev = '0; m_led = '0;
    for (int c = 0; c < NUM_CH; c++) m_trig[c] = NO_TRIG;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit              run_pre;
    int              cnt_pre, md, dt, age;
    bit              ls;
    bit [NUM_CH-1:0] nled;
    run_pre = (m_phase == PH_RUN);
    cnt_pre = m_run_age % (1 << CNT_W);
    nled = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      md  = int'(mode[2*c +: 2]);
      dt  = int'(duty[PWM_W*c +: PWM_W]);
      age = m_edge - m_trig[c];
      if (run_pre) begin
        case (md)
          1: nled[c] = ((cnt_pre >> (CNT_W - 1 - c)) & 1) != 0;
          2: nled[c] = (cnt_pre % (1 << PWM_W)) < dt;
          3: nled[c] = (age >= 1) && (age <= STRETCH_CYC);
          default: nled[c] = 1'b0;
        endcase
      end
      if (run_pre && md == 3) begin
        if (event_in[c] && !m_prev_ev[c]) m_trig[c] = m_edge;
      end else begin
        m_trig[c] = NO_TRIG;
      end
      m_prev_ev[c] = run_pre && event_in[c];
    end
    ls = m_lock_s;
    m_lock_s = m_sync1;
    m_sync1 = locked;
    case (m_phase)
      PH_WAIT: if (ls) begin m_phase = PH_SETTLE; m_settle = 0; end
      PH_SETTLE: begin
        if (!ls) m_phase = PH_WAIT;
        else if (m_settle == SETTLE_CYC - 1) begin m_phase = PH_RUN; m_run_age = 0; end
        else m_settle++;
      end
      default: begin
        if (!ls) begin
          m_phase = PH_WAIT;
          if (m_llc < 255) m_llc++;
        end else m_run_age++;
      end
    endcase
    m_led = nled;
    m_running = (m_phase == PH_RUN);
    m_edge++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_eq("led", 32'(led), 32'(m_led));
    chk_eq("running", 32'(running), 32'(m_running));
    chk_eq("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_llc));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Steps until running rises; returns the number of edges taken (bounded).
  task automatic wait_run(output int n, output bit led_seen);
    n = 0;
    led_seen = 0;
    while (!running && n < 40) begin
      step();
      n++;
      if (!running && led != '0) led_seen = 1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first3, hi0, hi_pwm [NUM_CH], hi1, first1;
    bit seen;

    rst_n = 1'b1; locked = 1'b0; mode = '0; duty = '0; event_in = '0;
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    chk_eq("rst_led", 32'(led), 0);
    chk_eq("rst_running", 32'(running), 0);
    chk_eq("rst_llc", 32'(lock_loss_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    steps(3);

    // Lock-up to RUN, all channels blinking
    locked = 1'b1;
    mode   = {NUM_CH{2'd1}};
    wait_run(n, seen);
    chk_eq("lock_to_run_edges", n, 11);
    chk_eq("led_idle_before_run", 32'(seen), 0);

    first3 = -1; hi0 = 0;
    for (int k = 1; k <= 128; k++) begin
      step();
      if (led[3] && first3 < 0) first3 = k;
      hi0 += int'(led[0]);
    end
    chk_eq("blink_ch3_first_rise", first3, 5);
    chk_eq("blink_ch0_high_128", hi0, 64);

    // PWM with fixed duties
    mode = {NUM_CH{2'd2}};
    duty = {4'd9, 4'd4, 4'd15, 4'd0};
    for (int c = 0; c < NUM_CH; c++) hi_pwm[c] = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      for (int c = 0; c < NUM_CH; c++) hi_pwm[c] += int'(led[c]);
    end
    chk_eq("pwm_duty0_high", hi_pwm[0], 0);
    chk_eq("pwm_duty15_high", hi_pwm[1], 60);
    chk_eq("pwm_duty4_high", hi_pwm[2], 16);
    chk_eq("pwm_duty9_high", hi_pwm[3], 36);

    // Random modes, duties and events
    for (int k = 0; k < 400; k++) begin
      mode     = (2*NUM_CH)'($urandom);
      duty     = (PWM_W*NUM_CH)'($urandom);
      event_in = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
      step();
    end

    // Stretch: single pulse, then retrigger on the 3rd high cycle
    mode = {NUM_CH{2'd3}};
    event_in = '0;
    steps(8);
    hi1 = 0; first1 = -1;
    for (int j = 0; j < 16; j++) begin
      event_in = (j == 0) ? 4'b0010 : 4'b0000;
      step();
      if (led[1]) begin
        hi1++;
        if (first1 < 0) first1 = j;
      end
    end
    chk_eq("stretch_single_len", hi1, STRETCH_CYC);
    chk_eq("stretch_single_start", first1, 1);
    hi1 = 0;
    for (int j = 0; j < 16; j++) begin
      event_in = (j == 0 || j == 3) ? 4'b0010 : 4'b0000;
      step();
      hi1 += int'(led[1]);
    end
    chk_eq("stretch_retrigger_len", hi1, 8);
    event_in = '0;

    // Lock loss in RUN
    locked = 1'b0;
    steps(4);
    chk_eq("lockloss_running", 32'(running), 0);
    chk_eq("lockloss_led", 32'(led), 0);
    chk_eq("lockloss_cnt1", 32'(lock_loss_cnt), 1);

    // Lock loss during SETTLE must not count
    locked = 1'b1;
    steps(5);
    locked = 1'b0;
    steps(5);
    chk_eq("settle_drop_cnt", 32'(lock_loss_cnt), 1);

    // Repeat until the counter saturates
    mode = {NUM_CH{2'd1}};
    for (int r = 0; r < 299; r++) begin
      locked = 1'b1;
      wait_run(n, seen);
      locked = 1'b0;
      steps(4);
    end
    chk_eq("lockloss_saturate", 32'(lock_loss_cnt), 255);

    // Async reset mid-RUN with stretch active
    locked = 1'b1;
    wait_run(n, seen);
    mode = {NUM_CH{2'd3}};
    event_in = '1;
    step();
    event_in = '0;
    steps(2);
    chk_eq("stretch_all_on", 32'(led), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_eq("arst_led", 32'(led), 0);
    chk_eq("arst_running", 32'(running), 0);
    chk_eq("arst_llc", 32'(lock_loss_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = {NUM_CH{2'd1}};
    wait_run(n, seen);
    chk_eq("restart_lock_to_run", n, 11);
    steps(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
